// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous load, wrap/saturate boundary modes,
// a combinational terminal-count decode and registered wrap/sat event flags.
module updown_mod_counter #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // Highest legal count. When MODULUS == 2**WIDTH this is all ones, so the
    // wrap path reduces to natural binary rollover.
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 64'd1);
    // One extra bit so a full 2**WIDTH modulus is representable for the clamp.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             sat_next;
    logic             at_top;
    logic             at_bottom;
    logic             load_over;

    assign at_top    = (q == Q_MAX);
    assign at_bottom = (q == '0);
    assign load_over = ({1'b0, load_val} >= MOD_EXT);

    // Terminal count follows q and the current direction with no latency.
    assign tc = updown ? at_top : at_bottom;

    // Next-state decode: load beats enable, enable beats hold.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        sat_next  = 1'b0;
        if (load) begin
            q_next = load_over ? Q_MAX : load_val;
        end else if (en) begin
            if (updown) begin
                if (!at_top) begin
                    q_next = q + WIDTH'(1);
                end else if (sat_mode) begin
                    sat_next = 1'b1;
                end else begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_bottom) begin
                    q_next = q - WIDTH'(1);
                end else if (sat_mode) begin
                    sat_next = 1'b1;
                end else begin
                    q_next    = Q_MAX;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    // Count and event-flag registers; reset clears them without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
            sat  <= sat_next;
        end
    end

endmodule
